// File: rtl/fir_mac_sequencer_if.sv
// ============================================================================
// Module   : fir_mac_sequencer_if
// Brief    : Sample-in / result-out valid-ready bundle for the FIR MAC engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fir_mac_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
);
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_data;
  logic                     m_valid;
  logic                     m_ready;
  logic signed [ACC_W-1:0]  m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
// ============================================================================
// Module   : fir_mac_sequencer
// Brief    : Time-multiplexed FIR controller driving one shared MAC over N taps.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fir_mac_sequencer #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int MAX_TAPS = 16,
  parameter int ACC_W    = 40
) (
  input  wire                              ACLK,
  input  wire                              ARESETN,
  input  wire [$clog2(MAX_TAPS):0]         cfg_ntaps,
  input  wire                              cfg_coef_we,
  input  wire [$clog2(MAX_TAPS)-1:0]       cfg_coef_addr,
  input  wire signed [COEF_W-1:0]          cfg_coef_data,
  input  wire                              cfg_clear,
  fir_mac_sequencer_if.slave               strm,
  output logic                             busy
);

  localparam int c_aw     = $clog2(MAX_TAPS);
  localparam int c_nt_w   = c_aw + 1;
  localparam int c_prod_w = DATA_W + COEF_W;
  localparam logic [c_nt_w-1:0] c_max_nt = c_nt_w'(MAX_TAPS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;

  logic signed [DATA_W-1:0]   r_buf  [MAX_TAPS];
  logic signed [COEF_W-1:0]   r_coef [MAX_TAPS];
  logic [c_aw-1:0]            r_wr_ptr;
  logic [c_nt_w-1:0]          r_k;
  logic [c_nt_w-1:0]          r_ntaps;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [c_prod_w-1:0] r_prod;
  logic                       r_prod_vld;
  logic                       r_issued;

  logic                       w_idle;
  logic                       w_s_ready;
  logic                       w_accept;
  logic [c_nt_w-1:0]          w_ntaps_eff;
  logic [c_aw-1:0]            w_rd_idx;
  logic signed [c_prod_w-1:0] w_mult;
  logic                       w_last_k;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_s_ready = w_idle && !cfg_clear;
  assign w_accept  = w_s_ready && strm.s_valid;

  always_comb begin
    w_ntaps_eff = cfg_ntaps;
    if ((cfg_ntaps == '0) || (cfg_ntaps > c_max_nt)) begin
      w_ntaps_eff = c_max_nt;
    end
  end

  // Newest sample pairs with coef[0]; older samples walk backwards around the ring.
  assign w_rd_idx = r_wr_ptr - r_k[c_aw-1:0];
  assign w_mult   = r_coef[r_k[c_aw-1:0]] * r_buf[w_rd_idx];
  assign w_last_k = (r_k == (r_ntaps - c_nt_w'(1)));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)     w_state_nxt = ST_MAC;
      ST_MAC:  if (r_issued)     w_state_nxt = ST_OUT;
      ST_OUT:  if (strm.m_ready) w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  // Products are registered, so the accumulate trails issue by one cycle and
  // the final add lands on the cycle that moves the FSM into OUT.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < MAX_TAPS; i++) begin
        r_buf[i]  <= '0;
        r_coef[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_k        <= '0;
      r_ntaps    <= c_max_nt;
      r_acc      <= '0;
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_issued   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_clear) begin
            for (int i = 0; i < MAX_TAPS; i++) begin
              r_buf[i] <= '0;
            end
            r_wr_ptr <= '0;
          end else if (strm.s_valid) begin
            r_buf[r_wr_ptr] <= strm.s_data;
            r_ntaps         <= w_ntaps_eff;
            r_acc           <= '0;
            r_k             <= '0;
            r_prod_vld      <= 1'b0;
            r_issued        <= 1'b0;
          end
          if (cfg_coef_we) begin
            r_coef[cfg_coef_addr] <= cfg_coef_data;
          end
        end
        ST_MAC: begin
          if (r_prod_vld) begin
            r_acc <= r_acc + ACC_W'(r_prod);
          end
          if (!r_issued) begin
            r_prod     <= w_mult;
            r_prod_vld <= 1'b1;
            r_k        <= r_k + 1'b1;
            if (w_last_k) begin
              r_issued <= 1'b1;
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end else begin
            r_prod_vld <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign strm.s_ready = w_s_ready;
  assign strm.m_valid = (r_state == ST_OUT);
  assign strm.m_data  = r_acc;
  assign busy         = !w_idle;

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
// ============================================================================
// Module   : tb_fir_mac_sequencer
// Brief    : Scoreboard bench for fir_mac_sequencer with a reference FIR model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fir_mac_sequencer;

  logic              ACLK;
  logic              ARESETN;
  logic [4:0]        cfg_ntaps;
  logic              cfg_coef_we;
  logic [3:0]        cfg_coef_addr;
  logic signed [15:0] cfg_coef_data;
  logic              cfg_clear;
  logic              busy;

  fir_mac_sequencer_if #(.DATA_W(16), .ACC_W(40)) bus ();

  fir_mac_sequencer #(
    .DATA_W(16), .COEF_W(16), .MAX_TAPS(16), .ACC_W(40)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .cfg_ntaps     (cfg_ntaps),
    .cfg_coef_we   (cfg_coef_we),
    .cfg_coef_addr (cfg_coef_addr),
    .cfg_coef_data (cfg_coef_data),
    .cfg_clear     (cfg_clear),
    .strm          (bus.slave),
    .busy          (busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: delay line, coefficients and write pointer.
  logic signed [15:0] mbuf [16];
  logic signed [15:0] mcoef [16];
  int mptr = 0;

  logic signed [39:0] exp_q [$];
  int                 lat_q [$];
  int                 acc_q [$];

  task automatic model_clear_buf();
    for (int i = 0; i < 16; i++) mbuf[i] = '0;
    mptr = 0;
  endtask

  task automatic model_reset();
    model_clear_buf();
    for (int i = 0; i < 16; i++) mcoef[i] = '0;
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
  endtask

  task automatic model_accept(input logic signed [15:0] d, input logic [4:0] nt,
                              input bit lat_chk, input int t);
    int n;
    longint s;
    logic [63:0] sv;
    n = (nt == 0 || nt > 16) ? 16 : int'(nt);
    mbuf[mptr] = d;
    s = 0;
    for (int k = 0; k < n; k++) s += longint'(mcoef[k]) * longint'(mbuf[(mptr - k) & 15]);
    sv = s;
    exp_q.push_back(sv[39:0]);
    lat_q.push_back(lat_chk ? n + 1 : -1);
    acc_q.push_back(t);
    mptr = (mptr + 1) % 16;
  endtask

  // Result monitor: each output handshake pops one expected result.
  logic signed [39:0] mon_e;
  int mon_l, mon_a;
  always @(negedge ACLK) begin
    if (ARESETN && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", bus.m_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_l = lat_q.pop_front();
        mon_a = acc_q.pop_front();
        chk("m_data", bus.m_data, mon_e);
        if (mon_l >= 0) chk("latency", cyc - mon_a, mon_l);
      end
    end
  end

  task automatic write_coef(input logic [3:0] a, input logic signed [15:0] d);
    @(posedge ACLK); #1;
    cfg_coef_we = 1'b1; cfg_coef_addr = a; cfg_coef_data = d;
    @(posedge ACLK); #1;
    cfg_coef_we = 1'b0;
    mcoef[a] = d;
  endtask

  task automatic clear_pulse();
    @(posedge ACLK); #1 cfg_clear = 1'b1;
    @(posedge ACLK); #1 cfg_clear = 1'b0;
    model_clear_buf();
  endtask

  task automatic send(input logic signed [15:0] d, input bit lat_chk);
    bit got;
    got = 1'b0;
    @(posedge ACLK); #1;
    bus.s_valid = 1'b1; bus.s_data = d;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge ACLK);
      if (bus.s_ready) got = 1'b1;
    end
    if (!got) chk("s_ready_timeout", bus.s_ready, 1'b1);
    @(posedge ACLK); #1;
    bus.s_valid = 1'b0;
    if (got) model_accept(d, cfg_ntaps, lat_chk, cyc);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || busy); i++) @(negedge ACLK);
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN = 1'b0;
    cfg_ntaps = 5'd4; cfg_coef_we = 1'b0; cfg_coef_addr = '0; cfg_coef_data = '0;
    cfg_clear = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
    model_reset();

    // Reset state
    repeat (20) @(posedge ACLK);
    #2 ARESETN = 1'b1;
    @(negedge ACLK);
    chk("rst_s_ready", bus.s_ready, 1'b1);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_data", bus.m_data, '0);

    // Impulse response
    write_coef(4'd0, 16'sd1); write_coef(4'd1, 16'sd2);
    write_coef(4'd2, 16'sd3); write_coef(4'd3, 16'sd4);
    cfg_ntaps = 5'd4;
    send(16'sd1, 1'b1);
    for (int i = 0; i < 4; i++) send(16'sd0, 1'b1);
    wait_drain();

    // Signed arithmetic
    cfg_ntaps = 5'd1;
    write_coef(4'd0, 16'shFFFF);
    send(16'sh7FFF, 1'b1);
    send(16'sh8000, 1'b1);
    wait_drain();

    // Backpressure, second sample held off until after the result handshake
    bus.m_ready = 1'b0;
    send(16'sd100, 1'b0);
    for (int i = 0; i < 100 && !bus.m_valid; i++) @(negedge ACLK);
    bus.s_valid = 1'b1; bus.s_data = 16'sd55;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      chk("bp_m_valid", bus.m_valid, 1'b1);
      chk("bp_m_data", bus.m_data, exp_q[0]);
      chk("bp_s_ready", bus.s_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
    end
    @(posedge ACLK); #1 bus.m_ready = 1'b1;
    @(negedge ACLK);
    chk("bp_hs_s_ready", bus.s_ready, 1'b0);
    @(negedge ACLK);
    chk("bp_after_s_ready", bus.s_ready, 1'b1);
    chk("bp_after_m_valid", bus.m_valid, 1'b0);
    @(posedge ACLK); #1;
    bus.s_valid = 1'b0;
    model_accept(16'sd55, cfg_ntaps, 1'b1, cyc);
    wait_drain();

    // Wrap-around over the full delay line, then ntaps=0 aliasing to 16
    clear_pulse();
    for (int i = 0; i < 16; i++) write_coef(4'(i), 16'sd1);
    cfg_ntaps = 5'd16;
    for (int i = 0; i < 20; i++) send(16'sd1, 1'b1);
    wait_drain();
    cfg_ntaps = 5'd0;
    send(16'sd1, 1'b1);
    wait_drain();

    // Coefficient write while busy is dropped
    cfg_ntaps = 5'd1;
    write_coef(4'd0, 16'sd3);
    send(16'sd7, 1'b1);
    cfg_coef_we = 1'b1; cfg_coef_addr = 4'd0; cfg_coef_data = 16'sd5;
    @(posedge ACLK); #1 cfg_coef_we = 1'b0;
    wait_drain();
    send(16'sd2, 1'b1);
    wait_drain();

    // Clear beats a simultaneous sample; next result sees an empty delay line
    @(posedge ACLK); #1;
    cfg_clear = 1'b1; bus.s_valid = 1'b1; bus.s_data = 16'sd9;
    @(negedge ACLK);
    chk("clr_s_ready", bus.s_ready, 1'b0);
    @(posedge ACLK); #1;
    cfg_clear = 1'b0; bus.s_valid = 1'b0;
    model_clear_buf();
    @(negedge ACLK);
    chk("clr_not_taken", busy, 1'b0);
    cfg_ntaps = 5'd4;
    send(16'sd5, 1'b1);
    wait_drain();

    // Asynchronous reset in the middle of MAC
    cfg_ntaps = 5'd16;
    send(16'sd3, 1'b0);
    repeat (3) @(posedge ACLK);
    #3 ARESETN = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_m_valid", bus.m_valid, 1'b0);
    chk("arst_m_data", bus.m_data, '0);
    model_reset();
    repeat (3) @(posedge ACLK);
    #2 ARESETN = 1'b1;
    repeat (20) @(negedge ACLK);
    chk("arst_no_out", exp_q.size(), 0);
    chk("arst_s_ready", bus.s_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
